// File: rtl/mnist_loader.sv
// Bit-serial loader for the MNIST accelerator: streams weights then inputs into
// banked memories, then hands the memories to the compute engine until it finishes.
module mnist_loader #(
  parameter int W_ADDR_LEN   = 20,
  parameter int X_ADDR_LEN   = 10,
  parameter int W_SEL_LEN    = 2,
  parameter int X_SEL_LEN    = 2,
  parameter int W_BANK_DEPTH = 1024,
  parameter int W_BANKS      = 4,
  parameter int X_BANK_DEPTH = 256,
  parameter int X_BANKS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_data,
  output logic                  w_wq_oc,
  output logic                  x_wq_oc,
  output logic [W_ADDR_LEN-1:0] w_addr_oc,
  output logic [X_ADDR_LEN-1:0] x_addr_oc,
  output logic                  wx_write_oc,
  output logic [W_SEL_LEN-1:0]  w_sel_oc,
  output logic [X_SEL_LEN-1:0]  x_sel_oc,
  output logic                  load_compute_ctrl,
  output logic                  en_compute,
  input  logic                  compute_finish,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, DRAIN, COMPUTE, DONE} state_t;

  state_t state_q, state_d;

  logic [W_ADDR_LEN-1:0] wCnt_q, wCnt_d, wAddr_q, wAddr_d;
  logic [X_ADDR_LEN-1:0] xCnt_q, xCnt_d, xAddr_q, xAddr_d;
  logic [W_SEL_LEN-1:0]  wBank_q, wBank_d, wSel_q, wSel_d;
  logic [X_SEL_LEN-1:0]  xBank_q, xBank_d, xSel_q, xSel_d;
  logic                  wWq_q, wWq_d, xWq_q, xWq_d, wxData_q, wxData_d;

  logic wBeat, xBeat, wAddrLast, wBankLast, xAddrLast, xBankLast;

  assign wBeat     = (state_q == LOAD_W) && s_valid;
  assign xBeat     = (state_q == LOAD_X) && s_valid;
  assign wAddrLast = (wCnt_q == W_ADDR_LEN'(W_BANK_DEPTH - 1));
  assign wBankLast = (wBank_q == W_SEL_LEN'(W_BANKS - 1));
  assign xAddrLast = (xCnt_q == X_ADDR_LEN'(X_BANK_DEPTH - 1));
  assign xBankLast = (xBank_q == X_SEL_LEN'(X_BANKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wCnt_q   <= '0;
      wBank_q  <= '0;
      xCnt_q   <= '0;
      xBank_q  <= '0;
      wAddr_q  <= '0;
      wSel_q   <= '0;
      xAddr_q  <= '0;
      xSel_q   <= '0;
      wWq_q    <= 1'b0;
      xWq_q    <= 1'b0;
      wxData_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wCnt_q   <= wCnt_d;
      wBank_q  <= wBank_d;
      xCnt_q   <= xCnt_d;
      xBank_q  <= xBank_d;
      wAddr_q  <= wAddr_d;
      wSel_q   <= wSel_d;
      xAddr_q  <= xAddr_d;
      xSel_q   <= xSel_d;
      wWq_q    <= wWq_d;
      xWq_q    <= xWq_d;
      wxData_q <= wxData_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = LOAD_W;
        LOAD_W:  if (wBeat && wAddrLast && wBankLast) state_d = LOAD_X;
        LOAD_X:  if (xBeat && xAddrLast && xBankLast) state_d = DRAIN;
        DRAIN:   state_d = COMPUTE;
        COMPUTE: if (compute_finish) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Beat datapath: the write strobe shows the pre-increment counter for one cycle,
  // while address/select/data keep their last value between beats.
  always_comb begin
    wCnt_d   = wCnt_q;
    wBank_d  = wBank_q;
    xCnt_d   = xCnt_q;
    xBank_d  = xBank_q;
    wAddr_d  = wAddr_q;
    wSel_d   = wSel_q;
    xAddr_d  = xAddr_q;
    xSel_d   = xSel_q;
    wxData_d = wxData_q;
    wWq_d    = 1'b0;
    xWq_d    = 1'b0;
    if (abort) begin
      wCnt_d   = '0;
      wBank_d  = '0;
      xCnt_d   = '0;
      xBank_d  = '0;
      wAddr_d  = '0;
      wSel_d   = '0;
      xAddr_d  = '0;
      xSel_d   = '0;
      wxData_d = 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        wCnt_d  = '0;
        wBank_d = '0;
        xCnt_d  = '0;
        xBank_d = '0;
      end
      if (wBeat) begin
        wWq_d    = 1'b1;
        wAddr_d  = wCnt_q;
        wSel_d   = wBank_q;
        wxData_d = s_data;
        if (wAddrLast) begin
          wCnt_d  = '0;
          wBank_d = wBank_q + 1'b1;
          if (wBankLast) begin
            xCnt_d  = '0;
            xBank_d = '0;
          end
        end else begin
          wCnt_d = wCnt_q + 1'b1;
        end
      end
      if (xBeat) begin
        xWq_d    = 1'b1;
        xAddr_d  = xCnt_q;
        xSel_d   = xBank_q;
        wxData_d = s_data;
        if (xAddrLast) begin
          xCnt_d  = '0;
          xBank_d = xBank_q + 1'b1;
        end else begin
          xCnt_d = xCnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_ready           = (state_q == LOAD_W) || (state_q == LOAD_X);
    busy              = (state_q != IDLE);
    en_compute        = (state_q == COMPUTE);
    load_compute_ctrl = (state_q != COMPUTE);
    done              = (state_q == DONE);
    w_wq_oc           = wWq_q;
    x_wq_oc           = xWq_q;
    w_addr_oc         = wAddr_q;
    x_addr_oc         = xAddr_q;
    w_sel_oc          = wSel_q;
    x_sel_oc          = xSel_q;
    wx_write_oc       = wxData_q;
  end

endmodule

// File: tb/tb_mnist_loader.sv
// Directed bench for mnist_loader with small banks: 2 weight banks of 4 bits and
// 2 input banks of 2 bits, so a full load is 12 stream beats.
module tb_mnist_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0, s_data = 1'b0;
  logic        compute_finish = 1'b0;
  logic        s_ready, w_wq_oc, x_wq_oc, wx_write_oc, load_compute_ctrl;
  logic        en_compute, busy, done;
  logic [19:0] w_addr_oc;
  logic [9:0]  x_addr_oc;
  logic [1:0]  w_sel_oc, x_sel_oc;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] pat = 12'b0110_1001_1101;
  int beats;
  int writes;
  int sv;

  mnist_loader #(
    .W_BANK_DEPTH(4), .W_BANKS(2), .X_BANK_DEPTH(2), .X_BANKS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .w_wq_oc(w_wq_oc), .x_wq_oc(x_wq_oc), .w_addr_oc(w_addr_oc), .x_addr_oc(x_addr_oc),
    .wx_write_oc(wx_write_oc), .w_sel_oc(w_sel_oc), .x_sel_oc(x_sel_oc),
    .load_compute_ctrl(load_compute_ctrl), .en_compute(en_compute),
    .compute_finish(compute_finish), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic v,
                               input logic d, input logic cf);
    start = st; abort = ab; s_valid = v; s_data = d; compute_finish = cf;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " s_ready"}, 32'(s_ready), 0);
    checkOutput({tag, " w_wq"}, 32'(w_wq_oc), 0);
    checkOutput({tag, " x_wq"}, 32'(x_wq_oc), 0);
    checkOutput({tag, " w_addr"}, 32'(w_addr_oc), 0);
    checkOutput({tag, " x_addr"}, 32'(x_addr_oc), 0);
    checkOutput({tag, " data"}, 32'(wx_write_oc), 0);
    checkOutput({tag, " w_sel"}, 32'(w_sel_oc), 0);
    checkOutput({tag, " x_sel"}, 32'(x_sel_oc), 0);
    checkOutput({tag, " lcc"}, 32'(load_compute_ctrl), 1);
    checkOutput({tag, " en"}, 32'(en_compute), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
  endtask

  initial begin
    // Reset values
    #2;
    checkIdle("reset");
    tick();
    rst = 1'b1;
    tick();

    // Full run with s_valid held high
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("run busy", 32'(busy), 1);
    checkOutput("run s_ready", 32'(s_ready), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, pat[i], 0);
      checkOutput($sformatf("run w_wq %0d", i), 32'(w_wq_oc), 1);
      checkOutput($sformatf("run w_addr %0d", i), 32'(w_addr_oc), i % 4);
      checkOutput($sformatf("run w_sel %0d", i), 32'(w_sel_oc), i / 4);
      checkOutput($sformatf("run w_data %0d", i), 32'(wx_write_oc), 32'(pat[i]));
      checkOutput($sformatf("run x_wq %0d", i), 32'(x_wq_oc), 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, pat[8+i], 0);
      checkOutput($sformatf("run x_wq %0d", i), 32'(x_wq_oc), 1);
      checkOutput($sformatf("run x_addr %0d", i), 32'(x_addr_oc), i % 2);
      checkOutput($sformatf("run x_sel %0d", i), 32'(x_sel_oc), i / 2);
      checkOutput($sformatf("run x_data %0d", i), 32'(wx_write_oc), 32'(pat[8+i]));
      checkOutput($sformatf("run w_wq x%0d", i), 32'(w_wq_oc), 0);
    end
    checkOutput("drain s_ready", 32'(s_ready), 0);
    checkOutput("drain lcc", 32'(load_compute_ctrl), 1);
    checkOutput("drain en", 32'(en_compute), 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("compute en", 32'(en_compute), 1);
    checkOutput("compute lcc", 32'(load_compute_ctrl), 0);
    checkOutput("compute x_wq", 32'(x_wq_oc), 0);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("compute en c%0d", i), 32'(en_compute), 1);
      checkOutput($sformatf("compute done c%0d", i), 32'(done), 0);
    end
    compute_finish = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("done en", 32'(en_compute), 0);
    checkOutput("done lcc", 32'(load_compute_ctrl), 1);
    checkOutput("done pulse", 32'(done), 1);
    checkOutput("done busy", 32'(busy), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("after done busy", 32'(busy), 0);
    checkOutput("after done pulse", 32'(done), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("after done pulse2", 32'(done), 0);

    // Random s_valid: order unchanged, one write per handshake
    applyStimulus(1, 0, 0, 0, 0);
    beats = 0;
    writes = 0;
    for (int c = 0; c < 400 && beats < 12; c++) begin
      sv = int'($urandom_range(0, 1));
      applyStimulus(0, 0, sv[0], pat[beats], 0);
      writes += int'(w_wq_oc) + int'(x_wq_oc);
      if (sv == 1) begin
        if (beats < 8) begin
          checkOutput($sformatf("rnd w_wq %0d", beats), 32'(w_wq_oc), 1);
          checkOutput($sformatf("rnd w_addr %0d", beats), 32'(w_addr_oc), beats % 4);
          checkOutput($sformatf("rnd w_sel %0d", beats), 32'(w_sel_oc), beats / 4);
        end else begin
          checkOutput($sformatf("rnd x_wq %0d", beats), 32'(x_wq_oc), 1);
          checkOutput($sformatf("rnd x_addr %0d", beats), 32'(x_addr_oc), (beats - 8) % 2);
          checkOutput($sformatf("rnd x_sel %0d", beats), 32'(x_sel_oc), (beats - 8) / 2);
        end
        checkOutput($sformatf("rnd data %0d", beats), 32'(wx_write_oc), 32'(pat[beats]));
        beats++;
      end else begin
        checkOutput($sformatf("rnd stall w_wq c%0d", c), 32'(w_wq_oc), 0);
        checkOutput($sformatf("rnd stall x_wq c%0d", c), 32'(x_wq_oc), 0);
      end
    end
    applyStimulus(0, 0, 1, 1, 0);
    writes += int'(w_wq_oc) + int'(x_wq_oc);
    checkOutput("rnd write count", 32'(writes), 12);
    checkOutput("rnd compute en", 32'(en_compute), 1);
    applyStimulus(0, 1, 0, 0, 0);
    checkIdle("rnd abort");

    // Abort on the third weight beat
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("abort pre addr", 32'(w_addr_oc), 1);
    applyStimulus(0, 1, 1, 1, 0);
    checkIdle("abort");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart s_ready", 32'(s_ready), 1);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("restart w_wq", 32'(w_wq_oc), 1);
    checkOutput("restart w_addr", 32'(w_addr_oc), 0);
    checkOutput("restart w_sel", 32'(w_sel_oc), 0);
    applyStimulus(0, 1, 0, 0, 0);

    // Start held high and compute_finish high during LOAD_W
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 1, pat[i], (i < 8) ? 1'b1 : 1'b0);
      if (i == 4) begin
        checkOutput("hold w_addr", 32'(w_addr_oc), 0);
        checkOutput("hold w_sel", 32'(w_sel_oc), 1);
        checkOutput("hold en", 32'(en_compute), 0);
        checkOutput("hold s_ready", 32'(s_ready), 1);
      end
    end
    checkOutput("hold drain x_addr", 32'(x_addr_oc), 1);
    checkOutput("hold drain s_ready", 32'(s_ready), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("hold compute en", 32'(en_compute), 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("hold done", 32'(done), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("hold idle busy", 32'(busy), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("hold restart s_ready", 32'(s_ready), 1);
    checkOutput("hold restart w_wq", 32'(w_wq_oc), 0);
    applyStimulus(0, 1, 0, 0, 0);

    // Reset pulse during COMPUTE
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, pat[i], 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst pre en", 32'(en_compute), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst async en", 32'(en_compute), 0);
    checkOutput("rst async lcc", 32'(load_compute_ctrl), 1);
    checkOutput("rst async busy", 32'(busy), 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput($sformatf("rst no done %0d", i), 32'(done), 0);
      checkOutput($sformatf("rst idle busy %0d", i), 32'(busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mnist_loader.md
MNIST_LOADER -- requirements
Module: mnist_loader

Interface
REQ-001 Parameters, one per line (name, default, meaning): W_ADDR_LEN 20 weight address width; X_ADDR_LEN 10 input address width; W_SEL_LEN 2 weight bank select width; X_SEL_LEN 2 input bank select width; W_BANK_DEPTH 1024 weight bits per bank; W_BANKS 4 weight banks loaded; X_BANK_DEPTH 256 input bits per bank; X_BANKS 4 input banks loaded.
REQ-002 Clock and reset: clk is the single clock; rst is asynchronous and active-low.
REQ-003 Ports, one per line (name, direction, width, meaning):
 - clk  in  1  clock, all state on rising edge
 - rst  in  1  async active-low reset
 - start  in  1  begin a load-and-compute sequence (sampled in IDLE only)
 - abort  in  1  synchronous abort to IDLE
 - s_valid  in  1  stream bit valid
 - s_ready  out  1  stream bit accepted
 - s_data  in  1  stream bit (all weights first, then all inputs)
 - w_wq_oc  out  1  weight memory write enable
 - x_wq_oc  out  1  input memory write enable
 - w_addr_oc  out  W_ADDR_LEN  weight address
 - x_addr_oc  out  X_ADDR_LEN  input address
 - wx_write_oc  out  1  write data bit
 - w_sel_oc  out  W_SEL_LEN  weight bank select
 - x_sel_oc  out  X_SEL_LEN  input bank select
 - load_compute_ctrl  out  1  1 = loader owns memory, 0 = compute engine owns it
 - en_compute  out  1  compute enable
 - compute_finish  in  1  compute engine done (level)
 - busy  out  1  high in any state except IDLE
 - done  out  1  one-cycle pulse on sequence completion

Function
REQ-004 FSM states: IDLE, LOAD_W, LOAD_X, DRAIN, COMPUTE, DONE.
REQ-005 IDLE: start=1 -> LOAD_W next cycle; weight and input counters cleared.
REQ-006 s_ready SHALL be 1 only in LOAD_W and LOAD_X; a beat transfers when s_valid and s_ready are both 1 on a rising edge.
REQ-007 Outputs are registered. A LOAD_W beat at edge N drives w_wq_oc=1, w_addr_oc=current weight address, w_sel_oc=current weight bank, wx_write_oc=s_data for exactly the cycle after edge N; x_wq_oc behaves the same way for LOAD_X beats.
REQ-008 Write enables are 0 in every cycle not produced by a beat; address, select and data hold their last values.
REQ-009 Address counter increments per beat; at BANK_DEPTH-1 it wraps to 0 and select increments.
REQ-010 Beat with weight address W_BANK_DEPTH-1 and select W_BANKS-1 -> LOAD_X; input counters start at 0.
REQ-011 Beat with input address X_BANK_DEPTH-1 and select X_BANKS-1 -> DRAIN.
REQ-012 DRAIN lasts one cycle with load_compute_ctrl=1 so the final write completes; it then goes to COMPUTE.
REQ-013 COMPUTE: load_compute_ctrl=0 and en_compute=1 every cycle. The first cycle with compute_finish=1 -> DONE, with en_compute=0 and load_compute_ctrl=1 from the next cycle.
REQ-014 compute_finish is ignored outside COMPUTE.
REQ-015 DONE: done=1 for one cycle, then IDLE.
REQ-016 s_valid low in LOAD states stalls: no write, counters hold, indefinitely.
REQ-017 abort=1 in any state -> IDLE next edge. Outputs return to reset values. An accepted beat in that same cycle is discarded with no write. Abort takes priority over start.
REQ-018 start while busy is ignored.

Reset
REQ-019 rst=0 immediately forces state IDLE and the following output values: s_ready 0, w_wq_oc 0, x_wq_oc 0, w_addr_oc 0, x_addr_oc 0, wx_write_oc 0, w_sel_oc 0, x_sel_oc 0, load_compute_ctrl 1, en_compute 0, busy 0, done 0.
REQ-020 Reset mid-sequence, including during COMPUTE, abandons the sequence; after release the block waits in IDLE for start.

Verification (params W_BANK_DEPTH=4, W_BANKS=2, X_BANK_DEPTH=2, X_BANKS=2)
REQ-021 Full run, s_valid always 1, pattern 1,0,1,1,...:
 - 8 w_wq_oc pulses at addr/sel (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1)
 - then 4 x_wq_oc pulses at (0,0),(1,0),(0,1),(1,1)
 - wx_write_oc matches the stream bits
 - DRAIN for 1 cycle, then en_compute=1
REQ-022 compute_finish raised 5 cycles into COMPUTE:
 - en_compute falls the next cycle
 - done pulses exactly once
 - busy=0 the cycle after done
REQ-023 s_valid toggled randomly: write count stays 12, address order unchanged, no write in any cycle without a preceding handshake.
REQ-024 abort asserted on the 3rd weight beat: that beat is not written; next cycle state is IDLE with all reset values; a new start restarts at (0,0).
REQ-025 rst pulsed low during COMPUTE: en_compute=0 and load_compute_ctrl=1 asynchronously; no done pulse.
REQ-026 start held high throughout a sequence: no restart until IDLE; compute_finish=1 during LOAD_W has no effect.
